// File: rtl/sprite_attr_writer.sv
// sprite_attr_writer
//   Write side of the sprite attribute table (X, Y, colour, shape-ID words for
//   64 sprites). Update commands are buffered in a small FIFO. Each command is
//   replayed as up to four single-word RAM writes, and only while the current
//   VGA line is inside the vertical write window. That window wraps through
//   line 0 and ends before the attribute fetch at line 31.
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   V_pos_in         current VGA line
//   cmd_valid/ready  command handshake (ready = FIFO not full)
//   cmd_index        sprite number 0..63
//   cmd_mask         field enables {ID,COLOR,Y,X}
//   cmd_x/y/color/id new field values
//   wren_out         RAM write strobe, one cycle per word
//   addr_out         RAM address (0 when wren_out=0)
//   data_out         RAM data (0 when wren_out=0)
//   busy             FSM active or FIFO non-empty
//   pending_count    FIFO occupancy
module sprite_attr_writer #(
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIN_START  = 512,
  parameter int unsigned WIN_END    = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  V_pos_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [3:0]  cmd_mask,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [15:0] cmd_color,
  input  logic [5:0]  cmd_id,
  output logic        wren_out,
  output logic [15:0] addr_out,
  output logic [15:0] data_out,
  output logic        busy,
  output logic [2:0]  pending_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [15:0] X_BASE     = 16'(BASE_ADDR);
  localparam logic [15:0] Y_BASE     = 16'(BASE_ADDR + 64);
  localparam logic [15:0] COLOR_BASE = 16'(BASE_ADDR + 128);
  localparam logic [15:0] ID_BASE    = 16'(BASE_ADDR + 192);

  typedef struct packed {
    logic [5:0]  idx;
    logic [3:0]  mask;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] color;
    logic [5:0]  id;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WR_X,
    WR_Y,
    WR_COLOR,
    WR_ID
  } state_t;

  state_t        state, state_nx;
  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          head, hold, cmd_in;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, win, push, pop;
  logic          wr_en_nx;
  logic [15:0]   wr_addr_nx, wr_data_nx;

  assign cmd_in = '{idx: cmd_index, mask: cmd_mask, x: cmd_x, y: cmd_y,
                    color: cmd_color, id: cmd_id};

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == LOAD);
  assign head      = fifo_mem[rd_ptr];

  assign win = (V_pos_in >= 10'(WIN_START)) || (V_pos_in <= 10'(WIN_END));

  assign busy          = (state != IDLE) || !empty;
  assign pending_count = 3'(count);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (!empty && win) state_nx = LOAD;
      LOAD:     state_nx = WR_X;
      WR_X:     state_nx = WR_Y;
      WR_Y:     state_nx = WR_COLOR;
      WR_COLOR: state_nx = WR_ID;
      WR_ID:    state_nx = (!empty && win) ? LOAD : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // The outputs are registered. This logic therefore computes, from the current
  // state, the word to present in the next state. On the LOAD->WR_X edge the
  // holding register is only being loaded, so the X word is taken directly from
  // the FIFO head.
  always_comb begin
    wr_en_nx   = 1'b0;
    wr_addr_nx = '0;
    wr_data_nx = '0;
    unique case (state)
      LOAD: begin
        wr_en_nx   = head.mask[0];
        wr_addr_nx = X_BASE + {10'b0, head.idx};
        wr_data_nx = {6'b0, head.x};
      end
      WR_X: begin
        wr_en_nx   = hold.mask[1];
        wr_addr_nx = Y_BASE + {10'b0, hold.idx};
        wr_data_nx = {6'b0, hold.y};
      end
      WR_Y: begin
        wr_en_nx   = hold.mask[2];
        wr_addr_nx = COLOR_BASE + {10'b0, hold.idx};
        wr_data_nx = hold.color;
      end
      WR_COLOR: begin
        wr_en_nx   = hold.mask[3];
        wr_addr_nx = ID_BASE + {10'b0, hold.idx};
        wr_data_nx = {10'b0, hold.id};
      end
      default: ;
    endcase
    if (!wr_en_nx) begin
      wr_addr_nx = '0;
      wr_data_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold     <= '0;
      wren_out <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      state    <= state_nx;
      wren_out <= wr_en_nx;
      addr_out <= wr_addr_nx;
      data_out <= wr_data_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        hold   <= head;
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

endmodule

// File: tb/tb_sprite_attr_writer.sv
module tb_sprite_attr_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  v_pos;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [3:0]  cmd_mask;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [15:0] cmd_color;
  logic [5:0]  cmd_id;
  logic        wren_out;
  logic [15:0] addr_out;
  logic [15:0] data_out;
  logic        busy;
  logic [2:0]  pending_count;

  always #5 clk = ~clk;

  sprite_attr_writer #(
    .BASE_ADDR(1024),
    .FIFO_DEPTH(4),
    .WIN_START(512),
    .WIN_END(29)
  ) dut (
    .clk(clk),
    .rst(rst),
    .V_pos_in(v_pos),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_index(cmd_index),
    .cmd_mask(cmd_mask),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_color(cmd_color),
    .cmd_id(cmd_id),
    .wren_out(wren_out),
    .addr_out(addr_out),
    .data_out(data_out),
    .busy(busy),
    .pending_count(pending_count)
  );

  int total = 0;
  int bad = 0;
  int wr_seen = 0;

  // Reference model: a queue of pending commands plus the command in flight.
  // slot: 0 idle, 1 load, 2..5 write slot for field (slot-2).
  typedef struct {
    int idx;
    int mask;
    int x;
    int y;
    int color;
    int id;
  } mcmd_t;

  mcmd_t mq[$];
  mcmd_t cur;
  int    slot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input int idx, input int mask, input int x,
                         input int y, input int color, input int id);
    cmd_valid = v;
    cmd_index = 6'(idx);
    cmd_mask  = 4'(mask);
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_color = 16'(color);
    cmd_id    = 6'(id);
  endtask

  // Advance the model and the DUT by one clock, then compare every output.
  task automatic tick();
    int    sz = mq.size();
    bit    w = (v_pos >= 512) || (v_pos <= 29);
    bit    acc = cmd_valid && (sz < 4);
    mcmd_t c;
    int    f;
    bit    e_wr;
    int    e_addr, e_data;
    c = '{idx: cmd_index, mask: cmd_mask, x: cmd_x, y: cmd_y, color: cmd_color, id: cmd_id};
    if (rst) begin
      mq.delete();
      slot = 0;
    end else begin
      case (slot)
        0: if (sz > 0 && w) slot = 1;
        1: begin cur = mq.pop_front(); slot = 2; end
        5: slot = (sz > 0 && w) ? 1 : 0;
        default: slot = slot + 1;
      endcase
      if (acc) mq.push_back(c);
    end
    e_wr = 0; e_addr = 0; e_data = 0;
    if (slot >= 2) begin
      f = slot - 2;
      e_wr = cur.mask[f];
      if (e_wr) begin
        e_addr = 1024 + 64 * f + cur.idx;
        e_data = (f == 0) ? cur.x : (f == 1) ? cur.y : (f == 2) ? cur.color : cur.id;
      end
    end
    @(posedge clk);
    #1;
    if (wren_out === 1'b1) wr_seen++;
    check("wren", 32'(wren_out), 32'(e_wr));
    check("addr", 32'(addr_out), 32'(e_addr));
    check("data", 32'(data_out), 32'(e_data));
    check("pending", 32'(pending_count), 32'(mq.size()));
    check("busy", 32'(busy), 32'((slot != 0) || (mq.size() != 0)));
    check("ready", 32'(cmd_ready), 32'(mq.size() < 4));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int v; bit valid; int idx; int mask; int x; int y; int color; int id;
    bit e_wr; int e_addr; int e_data; int e_pend; bit e_busy;
  } vec_t;

  vec_t vt[7];
  int   base, peak, tries;

  initial begin
    vt[0] = '{520, 1, 5, 15, 100, 200, 'hF800, 3, 0, 0, 0, 1, 1};
    vt[1] = '{520, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vt[2] = '{520, 0, 0, 0, 0, 0, 0, 0, 1, 1029, 100, 0, 1};
    vt[3] = '{520, 0, 0, 0, 0, 0, 0, 0, 1, 1093, 200, 0, 1};
    vt[4] = '{520, 0, 0, 0, 0, 0, 0, 0, 1, 1157, 'hF800, 0, 1};
    vt[5] = '{520, 0, 0, 0, 0, 0, 0, 0, 1, 1221, 3, 0, 1};
    vt[6] = '{520, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    v_pos = 10'd100;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    run(2);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;

    // 1: full-mask command inside the window
    foreach (vt[i]) begin
      v_pos = 10'(vt[i].v);
      set_cmd(vt[i].valid, vt[i].idx, vt[i].mask, vt[i].x, vt[i].y, vt[i].color, vt[i].id);
      tick();
      check("t1_wren", 32'(wren_out), 32'(vt[i].e_wr));
      check("t1_addr", 32'(addr_out), 32'(vt[i].e_addr));
      check("t1_data", 32'(data_out), 32'(vt[i].e_data));
      check("t1_pend", 32'(pending_count), 32'(vt[i].e_pend));
      check("t1_busy", 32'(busy), 32'(vt[i].e_busy));
    end

    // 2: command posted outside the window waits for line 512
    v_pos = 10'd100;
    base = wr_seen;
    set_cmd(1, 0, 1, 7, 0, 0, 0);
    tick();
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    run(8);
    check("t2_no_write", 32'(wr_seen - base), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    v_pos = 10'd512;
    run(8);
    check("t2_one_write", 32'(wr_seen - base), 32'd1);

    // 3: five back-to-back commands overflow the 4-entry FIFO
    v_pos = 10'd515;
    base = wr_seen;
    peak = 0;
    for (int k = 0; k < 5; k++) begin
      set_cmd(1, 10 + k, 15, k + 1, k + 2, k + 3, k + 4);
      tries = 0;
      while (cmd_ready !== 1'b1 && tries < 20) begin
        tick();
        tries++;
      end
      if (tries >= 20) check("t3_ready_timeout", 32'(tries), 32'd0);
      tick();
      if (int'(pending_count) > peak) peak = int'(pending_count);
    end
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    run(30);
    check("t3_peak", 32'(peak), 32'd4);
    check("t3_writes", 32'(wr_seen - base), 32'd20);

    // 4: window closes mid-command; the next command waits for line 512
    v_pos = 10'd29;
    base = wr_seen;
    set_cmd(1, 20, 15, 11, 12, 13, 14);
    tick();
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    tick();
    v_pos = 10'd30;
    set_cmd(1, 21, 15, 21, 22, 23, 24);
    tick();
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    run(5);
    check("t4_first_cmd", 32'(wr_seen - base), 32'd4);
    run(10);
    check("t4_held", 32'(wr_seen - base), 32'd4);
    check("t4_pending", 32'(pending_count), 32'd1);
    v_pos = 10'd512;
    run(8);
    check("t4_second_cmd", 32'(wr_seen - base), 32'd8);

    // 5: reset during the Y write abandons the remaining writes
    v_pos = 10'd520;
    base = wr_seen;
    set_cmd(1, 30, 15, 1, 2, 3, 4);
    tick();
    set_cmd(1, 31, 15, 5, 6, 7, 8);
    tick();
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    run(2);
    check("t5_y_write", 32'(addr_out), 32'd1024 + 32'd64 + 32'd30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_wren", 32'(wren_out), 32'd0);
    check("t5_pend", 32'(pending_count), 32'd0);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    run(8);
    check("t5_writes", 32'(wr_seen - base), 32'd2);

    // 6: partial mask writes only the Y and ID words
    base = wr_seen;
    set_cmd(1, 63, 4'b1010, 0, 9, 0, 2);
    tick();
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    run(7);
    check("t6_writes", 32'(wr_seen - base), 32'd2);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: v_pos = 10'(26 + $urandom_range(0, 7));
        1: v_pos = 10'(508 + $urandom_range(0, 7));
        2: v_pos = 10'($urandom_range(0, 1023));
        default: ;
      endcase
      rst = ($urandom_range(0, 99) == 0);
      set_cmd($urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom_range(0, 15),
              $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 65535),
              $urandom_range(0, 63));
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
